// File: rtl/logic_op_sequencer_pkg.sv
// Shared opcodes and FSM encodings for logic_op_sequencer.
// Imported by logicUnit and the sequencer top.
package logic_op_sequencer_pkg;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } state_e;

  function automatic logic op_legal(
    input logic [2:0] op
  );
    logic ok;
    ok = 1'b0;
    unique case (op)
      OP_AND,
      OP_OR,
      OP_XOR:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/logic_op_sequencer_logic_unit.sv
// logicUnit: combinational AND/OR/XOR unit; each result is only
// live when its opcode is presented, otherwise it reads zero.
// Ports: opCode[2:0], A[3:0], B[3:0] in; resultA/O/X[3:0] out.
module logicUnit
  import logic_op_sequencer_pkg::*;
(
  input  logic [2:0] opCode,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] resultA,
  output logic [3:0] resultO,
  output logic [3:0] resultX
);

  always_comb begin
    resultA = 4'b0000;
    resultO = 4'b0000;
    resultX = 4'b0000;
    if (opCode == OP_AND) begin
      resultA = A & B;
    end
    if (opCode == OP_OR) begin
      resultO = A | B;
    end
    if (opCode == OP_XOR) begin
      resultX = A ^ B;
    end
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Request/response sequencer around logicUnit with a saturating
// op counter. Ports: clk, rst (sync high); req{Valid,Ready,Op,A,B};
// rsp{Valid,Ready,Result,Err}; opCount[CNT_W-1:0].
module logic_op_sequencer
  import logic_op_sequencer_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reqValid,
  output logic             reqReady,
  input  logic [2:0]       reqOp,
  input  logic [3:0]       reqA,
  input  logic [3:0]       reqB,
  output logic             rspValid,
  input  logic             rspReady,
  output logic [3:0]       rspResult,
  output logic             rspErr,
  output logic [CNT_W-1:0] opCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       b_q, b_d;
  logic [3:0]       res_q, res_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0] lu_op;
  logic [3:0] lu_and;
  logic [3:0] lu_or;
  logic [3:0] lu_xor;

  // Unit only sees a real opcode while an op is in flight.
  assign lu_op = (state_q == ST_ISSUE ||
                  state_q == ST_CAPTURE) ? op_q : OP_NONE;

  logicUnit u_lu (
    .opCode  (lu_op),
    .A       (a_q),
    .B       (b_q),
    .resultA (lu_and),
    .resultO (lu_or),
    .resultX (lu_xor)
  );

  assign reqReady  = (state_q == ST_IDLE);
  assign rspValid  = (state_q == ST_RESPOND);
  assign rspResult = res_q;
  assign rspErr    = err_q;
  assign opCount   = cnt_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (reqValid) begin
          op_d  = reqOp;
          a_d   = reqA;
          b_d   = reqB;
          res_d = 4'b0000;
          if (op_legal(reqOp)) begin
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_RESPOND;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        unique case (1'b1)
          (op_q == OP_AND): res_d = lu_and;
          (op_q == OP_OR):  res_d = lu_or;
          (op_q == OP_XOR): res_d = lu_xor;
          default:          res_d = 4'b0000;
        endcase
        err_d   = 1'b0;
        state_d = ST_RESPOND;
      end
      ST_RESPOND: begin
        if (rspReady) begin
          if (!err_q && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          res_d   = 4'b0000;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= 3'b000;
      a_q     <= 4'b0000;
      b_q     <= 4'b0000;
      res_q   <= 4'b0000;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Randomized self-checking bench for logic_op_sequencer.
// Two DUTs (CNT_W=8 and CNT_W=2) share one stimulus stream.
module tb_logic_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       reqValid;
  logic [2:0] reqOp;
  logic [3:0] reqA;
  logic [3:0] reqB;
  logic       rspReady;

  logic       rdy8, vld8, err8;
  logic [3:0] res8;
  logic [7:0] cnt8;
  logic       rdy2, vld2, err2;
  logic [3:0] res2;
  logic [1:0] cnt2;

  int n_chk = 0;
  int n_pass = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  logic_op_sequencer #(.CNT_W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqReady  (rdy8),
    .reqOp     (reqOp),
    .reqA      (reqA),
    .reqB      (reqB),
    .rspValid  (vld8),
    .rspReady  (rspReady),
    .rspResult (res8),
    .rspErr    (err8),
    .opCount   (cnt8)
  );

  logic_op_sequencer #(.CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqReady  (rdy2),
    .reqOp     (reqOp),
    .reqA      (reqA),
    .reqB      (reqB),
    .rspValid  (vld2),
    .rspReady  (rspReady),
    .rspResult (res2),
    .rspErr    (err2),
    .opCount   (cnt2)
  );

  function automatic logic [7:0] exp8();
    return (cnt > 255) ? 8'd255 : 8'(cnt);
  endfunction

  function automatic logic [1:0] exp2();
    return (cnt > 3) ? 2'd3 : 2'(cnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; the model result comes from the
  // opcode table, and the expected latency from the op class.
  task automatic run_op(
    input logic [2:0] op,
    input logic [3:0] a,
    input logic [3:0] b,
    input int         stall,
    input bit         junk
  );
    logic [3:0] er;
    logic       ee;
    int         lat;
    ee = 1'b0;
    er = 4'b0000;
    case (op)
      3'b001:  er = a & b;
      3'b010:  er = a | b;
      3'b100:  er = a ^ b;
      default: ee = 1'b1;
    endcase
    n_chk++;
    if (rdy8 !== 1'b1)
      $display("FAIL req_ready_idle got %b exp 1", rdy8);
    else n_pass++;
    reqValid = 1'b1;
    reqOp    = op;
    reqA     = a;
    reqB     = b;
    rspReady = (stall == 0);
    tick();
    reqValid = junk;
    lat = 1;
    while (vld8 !== 1'b1 && lat < 8) begin
      n_chk++;
      if (rdy8 !== 1'b0 || vld2 !== 1'b0)
        $display("FAIL busy_ready got %b exp 0", rdy8);
      else n_pass++;
      if (junk) begin
        reqOp = 3'($urandom);
        reqA  = 4'($urandom);
        reqB  = 4'($urandom);
      end
      tick();
      lat++;
    end
    n_chk++;
    if (lat != (ee ? 1 : 3))
      $display("FAIL latency op=%b got %0d exp %0d",
               op, lat, ee ? 1 : 3);
    else n_pass++;
    n_chk++;
    if (res8 !== er || err8 !== ee)
      $display("FAIL rsp op=%b a=%h b=%h got %h/%b exp %h/%b",
               op, a, b, res8, err8, er, ee);
    else n_pass++;
    n_chk++;
    if (vld2 !== 1'b1 || res2 !== er || err2 !== ee)
      $display("FAIL rsp_w2 got %b/%h/%b exp 1/%h/%b",
               vld2, res2, err2, er, ee);
    else n_pass++;
    for (int i = 0; i < stall; i++) begin
      if (junk) begin
        reqOp = 3'($urandom);
        reqA  = 4'($urandom);
      end
      tick();
      n_chk++;
      if (vld8 !== 1'b1 || rdy8 !== 1'b0 ||
          res8 !== er || err8 !== ee)
        $display("FAIL hold cyc=%0d got v%b r%b %h/%b exp v1 r0 %h/%b",
                 i, vld8, rdy8, res8, err8, er, ee);
      else n_pass++;
    end
    rspReady = 1'b1;
    tick();
    reqValid = 1'b0;
    rspReady = 1'b0;
    if (!ee) cnt++;
    n_chk++;
    if (vld8 !== 1'b0 || rdy8 !== 1'b1)
      $display("FAIL after_hs got v%b r%b exp v0 r1", vld8, rdy8);
    else n_pass++;
    n_chk++;
    if (cnt8 !== exp8() || cnt2 !== exp2())
      $display("FAIL op_count got %0d/%0d exp %0d/%0d",
               cnt8, cnt2, exp8(), exp2());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    reqValid = 1'b1;
    reqOp    = 3'b001;
    reqA     = 4'hF;
    reqB     = 4'hF;
    rspReady = 1'b1;
    tick();
    tick();
    n_chk++;
    if (rdy8 !== 1'b1 || vld8 !== 1'b0 || res8 !== 4'h0 ||
        err8 !== 1'b0 || cnt8 !== 8'd0 || cnt2 !== 2'd0)
      $display("FAIL reset got r%b v%b %h/%b c%0d exp r1 v0 0/0 c0",
               rdy8, vld8, res8, err8, cnt8);
    else n_pass++;
    rst      = 1'b0;
    reqValid = 1'b0;
    rspReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (vld8 !== 1'b0 || rdy8 !== 1'b1)
        $display("FAIL reset_idle got v%b r%b exp v0 r1",
                 vld8, rdy8);
      else n_pass++;
    end
  endtask

  task automatic test_and();
    run_op(3'b001, 4'b0011, 4'b0001, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_op(3'b010, 4'b1001, 4'b0101, 0, 1'b1);
    run_op(3'b100, 4'b1111, 4'b1111, 0, 1'b1);
  endtask

  task automatic test_illegal();
    run_op(3'b011, 4'hA, 4'h5, 0, 1'b0);
    run_op(3'b111, 4'hF, 4'hF, 2, 1'b1);
  endtask

  task automatic test_backpressure();
    run_op(3'b100, 4'b1010, 4'b0110, 5, 1'b1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      run_op(3'b010, 4'(i), 4'(i + 3), 0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [2:0] op;
    int         r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3) op = 3'b001;
      else if (r < 6) op = 3'b010;
      else if (r < 9) op = 3'b100;
      else begin
        op = 3'($urandom);
        while (op == 3'b001 || op == 3'b010 || op == 3'b100)
          op = 3'($urandom);
      end
      run_op(op, 4'($urandom), 4'($urandom),
             $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_op();
    reqValid = 1'b1;
    reqOp    = 3'b001;
    reqA     = 4'hF;
    reqB     = 4'h7;
    rspReady = 1'b1;
    tick();
    reqValid = 1'b0;
    tick();
    n_chk++;
    if (vld8 !== 1'b0 || rdy8 !== 1'b0)
      $display("FAIL capture_state got v%b r%b exp v0 r0",
               vld8, rdy8);
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    n_chk++;
    if (vld8 !== 1'b0 || res8 !== 4'h0 || err8 !== 1'b0 ||
        cnt8 !== 8'd0 || cnt2 !== 2'd0)
      $display("FAIL mid_reset got v%b %h/%b c%0d/%0d exp v0 0/0 c0",
               vld8, res8, err8, cnt8, cnt2);
    else n_pass++;
    tick();
    n_chk++;
    if (rdy8 !== 1'b1 || vld8 !== 1'b0)
      $display("FAIL mid_reset_ready got r%b v%b exp r1 v0",
               rdy8, vld8);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if (vld8 !== 1'b0)
        $display("FAIL mid_reset_norsp got %b exp 0", vld8);
      else n_pass++;
    end
    rspReady = 1'b0;
    run_op(3'b001, 4'b1100, 4'b1010, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_and();
    test_back_to_back();
    test_illegal();
    test_backpressure();
    test_saturation();
    test_random();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
